// File: rtl/sram_oq_write_arbiter.sv
// Write-side scheduler of the SRAM output queue: round-robin source pick, packet streaming, pointer commit.
// Optional statistics counters are built when SRAM_OQ_ARB_STATS_EN is defined.
module sram_oq_write_arbiter #(
    parameter int NUM_IN       = 2,
    parameter int DATA_WIDTH   = 202,
    parameter int NUM_OQ       = 5,
    parameter int QADDR_WIDTH  = 16,
    parameter int OQ_IDX_WIDTH = 3
) (
    input  logic                                 memclk,
    input  logic                                 memreset,
    input  logic [NUM_IN*DATA_WIDTH-1:0]         in_dout,
    input  logic [NUM_IN-1:0]                    in_dout_valid,
    input  logic [NUM_IN*NUM_OQ-1:0]             in_oq,
    output logic [NUM_IN-1:0]                    in_output_enable,
    input  logic                                 sram_wr_ready,
    output logic                                 sram_wr_en,
    output logic [OQ_IDX_WIDTH+QADDR_WIDTH-1:0]  sram_wr_addr,
    output logic [DATA_WIDTH-1:0]                sram_wr_data,
    input  logic [NUM_OQ*(QADDR_WIDTH+1)-1:0]    oq_rd_ptr,
    output logic [NUM_OQ*(QADDR_WIDTH+1)-1:0]    oq_wr_ptr,
    output logic [NUM_OQ-1:0]                    oq_pkt_done,
    output logic [NUM_OQ*32-1:0]                 oq_pkt_cnt,
    output logic [31:0]                          drop_cnt
);

    localparam int PW = QADDR_WIDTH + 1;
    localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int AW = OQ_IDX_WIDTH + QADDR_WIDTH;
    localparam logic [PW-1:0] FULL_DIST = {1'b1, {QADDR_WIDTH{1'b0}}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DROP   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_q, last_d;
    logic [OQ_IDX_WIDTH-1:0] dest_q, dest_d;
    logic [PW-1:0]           work_ptr_q [NUM_OQ];
    logic [PW-1:0]           work_ptr_d [NUM_OQ];
    logic [PW-1:0]           wr_ptr_q   [NUM_OQ];
    logic [PW-1:0]           rd_ptr     [NUM_OQ];

    logic                    wr_en_q;
    logic [AW-1:0]           wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic                    c1_q, c2_q;
    logic [OQ_IDX_WIDTH-1:0] c1_dest_q, c2_dest_q;
    logic [PW-1:0]           c1_ptr_q, c2_ptr_q;
    logic [NUM_OQ-1:0]       done_q, done_d;

    logic                    req_found;
    logic [GW-1:0]           pick;
    logic [NUM_OQ-1:0]       pick_oq;
    logic [OQ_IDX_WIDTH-1:0] pick_dest;
    logic                    cur_valid;
    logic [DATA_WIDTH-1:0]   cur_word;
    logic                    cur_eop;
    logic [PW-1:0]           ptr_diff;
    logic                    cur_full;
    logic                    consume;
    logic                    wr_fire;
    logic                    commit_now;
    logic                    drop_eop;

    for (genvar q = 0; q < NUM_OQ; q++) begin : g_ptr
        assign rd_ptr[q]              = oq_rd_ptr[q*PW +: PW];
        assign oq_wr_ptr[q*PW +: PW]  = wr_ptr_q[q];
    end

    // Round-robin: first valid source strictly after the previous winner.
    always_comb begin
        req_found = 1'b0;
        pick      = last_q;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!req_found && in_dout_valid[(int'(last_q) + k) % NUM_IN]) begin
                req_found = 1'b1;
                pick      = GW'((int'(last_q) + k) % NUM_IN);
            end
        end
    end

    assign pick_oq = in_oq[int'(pick)*NUM_OQ +: NUM_OQ];

    always_comb begin
        pick_dest = '0;
        for (int q = NUM_OQ - 1; q >= 0; q--) begin
            if (pick_oq[q]) begin
                pick_dest = OQ_IDX_WIDTH'(q);
            end
        end
    end

    assign cur_valid = in_dout_valid[grant_q];
    assign cur_word  = in_dout[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_eop   = cur_word[DATA_WIDTH-1];
    assign ptr_diff  = work_ptr_q[dest_q] - rd_ptr[dest_q];
    assign cur_full  = (ptr_diff == FULL_DIST);

    always_comb begin
        in_output_enable = '0;
        case (state_q)
            S_STREAM: in_output_enable[grant_q] = sram_wr_ready && !cur_full;
            S_DROP:   in_output_enable[grant_q] = 1'b1;
            default:  in_output_enable = '0;
        endcase
    end

    assign consume    = in_output_enable[grant_q] && cur_valid;
    assign wr_fire    = (state_q == S_STREAM) && consume;
    assign commit_now = wr_fire && cur_eop;
    assign drop_eop   = (state_q == S_DROP) && consume && cur_eop;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        dest_d  = dest_q;
        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    grant_d = pick;
                    dest_d  = pick_dest;
                    state_d = (|pick_oq) ? S_STREAM : S_DROP;
                end
            end
            S_STREAM, S_DROP: begin
                if (consume && cur_eop) begin
                    state_d = S_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        work_ptr_d = work_ptr_q;
        if (wr_fire) begin
            work_ptr_d[dest_q] = work_ptr_q[dest_q] + 1'b1;
        end
    end

    always_comb begin
        done_d = '0;
        if (c2_q) begin
            done_d[c2_dest_q] = 1'b1;
        end
    end

    // Commit lags the EOP consume by two edges so the EOP write has issued first.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_IN - 1);
            dest_q    <= '0;
            for (int q = 0; q < NUM_OQ; q++) begin
                work_ptr_q[q] <= '0;
                wr_ptr_q[q]   <= '0;
            end
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            c1_q      <= 1'b0;
            c2_q      <= 1'b0;
            c1_dest_q <= '0;
            c2_dest_q <= '0;
            c1_ptr_q  <= '0;
            c2_ptr_q  <= '0;
            done_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            dest_q     <= dest_d;
            work_ptr_q <= work_ptr_d;
            wr_en_q    <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= {dest_q, work_ptr_q[dest_q][QADDR_WIDTH-1:0]};
                wr_data_q <= cur_word;
            end
            c1_q      <= commit_now;
            c1_dest_q <= dest_q;
            c1_ptr_q  <= work_ptr_d[dest_q];
            c2_q      <= c1_q;
            c2_dest_q <= c1_dest_q;
            c2_ptr_q  <= c1_ptr_q;
            done_q    <= done_d;
            if (c2_q) begin
                wr_ptr_q[c2_dest_q] <= c2_ptr_q;
            end
        end
    end

    assign sram_wr_en   = wr_en_q;
    assign sram_wr_addr = wr_addr_q;
    assign sram_wr_data = wr_data_q;
    assign oq_pkt_done  = done_q;

`ifdef SRAM_OQ_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_OQ];
    logic [31:0] drop_cnt_q;

    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) begin
            for (int q = 0; q < NUM_OQ; q++) begin
                pkt_cnt_q[q] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            if (c2_q) begin
                pkt_cnt_q[c2_dest_q] <= pkt_cnt_q[c2_dest_q] + 32'd1;
            end
            if (drop_eop) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    for (genvar q = 0; q < NUM_OQ; q++) begin : g_cnt
        assign oq_pkt_cnt[q*32 +: 32] = pkt_cnt_q[q];
    end
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_eop;
    assign oq_pkt_cnt  = '0;
    assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_sram_oq_write_arbiter.sv
// Directed bench for sram_oq_write_arbiter with QADDR_WIDTH=4 and 16-bit words.
// Source queues model the converters; writes and commit pulses are logged per cycle.
module tb_sram_oq_write_arbiter;

    localparam int NI = 2;
    localparam int DW = 16;
    localparam int NO = 5;
    localparam int QW = 4;
    localparam int IW = 3;
    localparam int PW = QW + 1;
    localparam int AW = IW + QW;
`ifdef SRAM_OQ_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic               memclk = 1'b0;
    logic               memreset;
    logic [NI*DW-1:0]   in_dout;
    logic [NI-1:0]      in_dout_valid;
    logic [NI*NO-1:0]   in_oq;
    logic [NI-1:0]      in_output_enable;
    logic               sram_wr_ready;
    logic               sram_wr_en;
    logic [AW-1:0]      sram_wr_addr;
    logic [DW-1:0]      sram_wr_data;
    logic [NO*PW-1:0]   oq_rd_ptr;
    logic [NO*PW-1:0]   oq_wr_ptr;
    logic [NO-1:0]      oq_pkt_done;
    logic [NO*32-1:0]   oq_pkt_cnt;
    logic [31:0]        drop_cnt;

    sram_oq_write_arbiter #(
        .NUM_IN(NI), .DATA_WIDTH(DW), .NUM_OQ(NO),
        .QADDR_WIDTH(QW), .OQ_IDX_WIDTH(IW)
    ) dut (
        .memclk(memclk),
        .memreset(memreset),
        .in_dout(in_dout),
        .in_dout_valid(in_dout_valid),
        .in_oq(in_oq),
        .in_output_enable(in_output_enable),
        .sram_wr_ready(sram_wr_ready),
        .sram_wr_en(sram_wr_en),
        .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data),
        .oq_rd_ptr(oq_rd_ptr),
        .oq_wr_ptr(oq_wr_ptr),
        .oq_pkt_done(oq_pkt_done),
        .oq_pkt_cnt(oq_pkt_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 memclk = ~memclk;

    logic [DW-1:0] srcq0[$];
    logic [DW-1:0] srcq1[$];
    logic [NO-1:0] src_oq0, src_oq1;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int done_n [NO];
    int cyc_n, eop_cyc, done_cyc, multi_en;
    int total, bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] wptr(input int q);
        return oq_wr_ptr[q*PW +: PW];
    endfunction

    function automatic logic [31:0] pcnt(input int q);
        return oq_pkt_cnt[q*32 +: 32];
    endfunction

    task automatic clear_logs();
        srcq0.delete();
        srcq1.delete();
        wa.delete();
        wd.delete();
        for (int q = 0; q < NO; q++) done_n[q] = 0;
        multi_en = 0;
        eop_cyc  = -100;
        done_cyc = -200;
    endtask

    // One clock: present heads, note what the DUT consumes, pop after the edge.
    task automatic cyc();
        logic [NI-1:0] cons;
        logic [DW-1:0] w;
        in_dout_valid[0] = (srcq0.size() > 0);
        in_dout_valid[1] = (srcq1.size() > 0);
        in_dout[0 +: DW]  = (srcq0.size() > 0) ? srcq0[0] : '0;
        in_dout[DW +: DW] = (srcq1.size() > 0) ? srcq1[0] : '0;
        in_oq = {src_oq1, src_oq0};
        #1;
        cons = in_output_enable & in_dout_valid;
        if ($countones(in_output_enable) > 1) multi_en++;
        @(posedge memclk);
        cyc_n++;
        if (cons[0]) begin
            w = srcq0.pop_front();
            if (w[DW-1]) eop_cyc = cyc_n;
        end
        if (cons[1]) begin
            w = srcq1.pop_front();
            if (w[DW-1]) eop_cyc = cyc_n;
        end
        #1;
        if (sram_wr_en) begin
            wa.push_back(sram_wr_addr);
            wd.push_back(sram_wr_data);
        end
        for (int q = 0; q < NO; q++) begin
            if (oq_pkt_done[q]) begin
                done_n[q]++;
                done_cyc = cyc_n;
            end
        end
        @(negedge memclk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        memreset = 1'b1;
        @(negedge memclk);
        @(negedge memclk);
        memreset = 1'b0;
        clear_logs();
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc_n = 0;
        memreset = 1'b1;
        in_dout = '0;
        in_dout_valid = '0;
        in_oq = '0;
        sram_wr_ready = 1'b1;
        oq_rd_ptr = '0;
        src_oq0 = '0;
        src_oq1 = '0;
        clear_logs();
        @(negedge memclk);
        @(negedge memclk);
        memreset = 1'b0;
        @(negedge memclk);

        chk("rst_en", in_output_enable, 0);
        chk("rst_wr_en", sram_wr_en, 0);
        chk("rst_addr", sram_wr_addr, 0);
        chk("rst_data", sram_wr_data, 0);
        chk("rst_wr_ptr", oq_wr_ptr, 0);
        chk("rst_done", oq_pkt_done, 0);
        chk("rst_pkt_cnt", oq_pkt_cnt, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single 3-word packet into queue 2
        src_oq0 = 5'b00100;
        srcq0.push_back(16'h0A01);
        srcq0.push_back(16'h0A02);
        srcq0.push_back(16'h8A03);
        run(10);
        chk("t1_nwr", wa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa.size()) begin
                chk("t1_addr", wa[i], 7'h20 + i);
                chk("t1_data", wd[i], (i == 2) ? 16'h8A03 : 16'h0A01 + i);
            end
        end
        chk("t1_wr_ptr2", wptr(2), 3);
        chk("t1_done_n", done_n[2], 1);
        chk("t1_done_lat", done_cyc - eop_cyc, 2);
        chk("t1_pkt_cnt2", pcnt(2), STATS);

        // Two sources contending, 2-word packets into queue 1
        do_reset();
        src_oq0 = 5'b00010;
        src_oq1 = 5'b00010;
        srcq0.push_back(16'h1001); srcq0.push_back(16'h9002);
        srcq0.push_back(16'h1003); srcq0.push_back(16'h9004);
        srcq1.push_back(16'h2001); srcq1.push_back(16'hA002);
        srcq1.push_back(16'h2003); srcq1.push_back(16'hA004);
        run(20);
        begin
            logic [DW-1:0] exp_d [8];
            exp_d = '{16'h1001, 16'h9002, 16'h2001, 16'hA002,
                      16'h1003, 16'h9004, 16'h2003, 16'hA004};
            chk("t2_nwr", wa.size(), 8);
            for (int i = 0; i < 8; i++) begin
                if (i < wa.size()) begin
                    chk("t2_addr", wa[i], 7'h10 + i);
                    chk("t2_data", wd[i], exp_d[i]);
                end
            end
        end
        chk("t2_onehot", multi_en, 0);
        chk("t2_wr_ptr1", wptr(1), 8);
        chk("t2_done_n", done_n[1], 4);

        // 20-word packet into queue 0 stalls on full, resumes on reader progress
        do_reset();
        src_oq0 = 5'b00001;
        for (int i = 0; i < 20; i++)
            srcq0.push_back((i == 19) ? (16'h8300 + 16'(i)) : (16'h0300 + 16'(i)));
        run(30);
        chk("t3_nwr_full", wa.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < wa.size()) chk("t3_addr_a", wa[i], i);
        chk("t3_en_stall", in_output_enable, 0);
        chk("t3_wr_ptr_unc", wptr(0), 0);
        oq_rd_ptr[0 +: PW] = 5'd4;
        run(10);
        chk("t3_nwr_all", wa.size(), 20);
        for (int i = 16; i < 20; i++) begin
            if (i < wa.size()) begin
                chk("t3_addr_b", wa[i], i - 16);
                chk("t3_data_b", wd[i], (i == 19) ? 16'h8313 : 16'h0300 + i);
            end
        end
        chk("t3_wr_ptr0", wptr(0), 5'd20);
        chk("t3_done_n", done_n[0], 1);

        // Packet with no destination is drained and dropped
        do_reset();
        src_oq0 = 5'b00000;
        srcq0.push_back(16'h0401); srcq0.push_back(16'h0402);
        srcq0.push_back(16'h0403); srcq0.push_back(16'h8404);
        run(10);
        chk("t4_consumed", srcq0.size(), 0);
        chk("t4_nwr", wa.size(), 0);
        chk("t4_drop", drop_cnt, STATS);
        chk("t4_wr_ptr", oq_wr_ptr, 0);

        // Ready toggling every cycle, source 1 into queue 3
        src_oq1 = 5'b01000;
        for (int i = 0; i < 6; i++)
            srcq1.push_back((i == 5) ? (16'h8500 + 16'(i)) : (16'h0500 + 16'(i)));
        sram_wr_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sram_wr_ready = ~sram_wr_ready;
            cyc();
        end
        sram_wr_ready = 1'b1;
        chk("t5_nwr", wa.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                chk("t5_addr", wa[i], 7'h30 + i);
                chk("t5_data", wd[i], (i == 5) ? 16'h8505 : 16'h0500 + i);
            end
        end
        chk("t5_wr_ptr3", wptr(3), 6);
        chk("t5_pkt_cnt3", pcnt(3), STATS);

        // Reset in the middle of a packet
        src_oq0 = 5'b00100;
        for (int i = 0; i < 6; i++)
            srcq0.push_back((i == 5) ? 16'h8605 : (16'h0600 + 16'(i)));
        run(3);
        memreset = 1'b1;
        #1;
        chk("t6_en", in_output_enable, 0);
        chk("t6_wr_en", sram_wr_en, 0);
        chk("t6_addr", sram_wr_addr, 0);
        chk("t6_data", sram_wr_data, 0);
        chk("t6_wr_ptr", oq_wr_ptr, 0);
        chk("t6_pkt_cnt", oq_pkt_cnt, 0);
        chk("t6_drop", drop_cnt, 0);
        @(negedge memclk);
        memreset = 1'b0;
        clear_logs();
        srcq0.push_back(16'h0701);
        srcq0.push_back(16'h8702);
        run(8);
        chk("t6_nwr", wa.size(), 2);
        if (wa.size() > 0) begin
            chk("t6_addr0", wa[0], 7'h20);
            chk("t6_data0", wd[0], 16'h0701);
        end
        chk("t6_wr_ptr2", wptr(2), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
